rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin arbiter that shares one downstream resource among NUM_REQ requesters. It sits between the requesting blocks and the shared datapath or bus, and grants ownership to one requester at a time. Rotating priority guarantees fairness, and a hold limit bounds how long any one owner keeps the resource. A mandatory one-cycle gap separates consecutive grants so the downstream mux can switch cleanly.

## Interface
- NUM_REQ, default 4: number of requesters. Legal range 2..16.
- MAX_HOLD, default 16: maximum consecutive grant cycles per ownership. Legal range 1..255.
- IDX_W: derived localparam, ceil(log2(NUM_REQ)). It is computed by a constant function, not overridable.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level. Held high while the requester wants or keeps ownership.
- gnt  output  NUM_REQ  one-hot grant, registered. All zero when no owner.
- gnt_valid  output  1  high iff gnt is nonzero; registered.
- gnt_idx  output  IDX_W  index of current owner; holds last owner when gnt_valid=0.
- hold_expired  output  1  one-cycle pulse, registered. Asserted in the cycle after a grant is revoked by the hold limit.

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, hold_expired=0, FSM=IDLE, priority pointer=0, hold counter=0.
- Priority pointer ptr names the highest-priority requester. The search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (wrap-around).
- FSM has three states:
  - IDLE: if any req bit is set, select the first set bit in search order. Load gnt/gnt_idx for that index, set gnt_valid, clear the hold counter, and go to OWN. If no req bit is set, stay in IDLE.
  - OWN: the hold counter increments each cycle. Leave OWN on either of two conditions (owner release has priority in naming only; both actions are identical):
    - req[gnt_idx]=0 (owner released).
    - The counter reaches MAX_HOLD-1 with req still high (limit); in this case set hold_expired for one cycle.
    - On leaving: clear gnt/gnt_valid, set ptr = gnt_idx+1 (mod NUM_REQ), and go to GAP.
  - GAP: exactly one cycle with gnt=0, then go to IDLE.
- The owner's req deasserting is the only release mechanism. Other requesters' req changes during OWN have no effect.
- A requester whose grant expired and keeps req high rejoins arbitration at lowest priority, because ptr moved past it.
- Reset asserted in any state, including mid-ownership, forces the reset values on the next edge. There is no drain or completion of the current ownership.
- Only one grant is ever active; gnt is always zero or one-hot.

## Timing
- Arbitration latency: req sampled in IDLE at edge N gives gnt high after edge N. Equivalently, gnt is visible the cycle after req is first seen in IDLE.
- Minimum grant length is 1 cycle; maximum is MAX_HOLD cycles.
- Release: the owner drops req in cycle C, and gnt drops after the edge ending cycle C. The requester must tolerate one extra granted cycle.
- Grant-to-grant spacing is at least 2 cycles of gnt=0: one GAP cycle plus one IDLE arbitration cycle.
- When all requesters hold req continuously, each owns MAX_HOLD cycles. Grants then rotate 0,1,2,…,NUM_REQ-1,0 with a period of NUM_REQ*(MAX_HOLD+2) cycles.
- hold_expired is coincident with the first GAP cycle.
- The counter width is 8 bits; it never wraps because it stops at MAX_HOLD-1.

## Test plan
- Reset check: assert rst for 3 cycles with req=4'b1111 → gnt=0, gnt_valid=0, gnt_idx=0, hold_expired=0 throughout. The first grant after reset goes to index 0.
- Single short request: req=4'b0100 for 3 cycles, then 0 → gnt=4'b0100 for 3 cycles starting one cycle after req rises, gnt_idx=2. Then GAP, ptr=3, hold_expired never set.
- Hold limit, MAX_HOLD=4: req=4'b0001 held high → gnt=4'b0001 for exactly 4 cycles, hold_expired pulses once, 2 zero cycles follow, then requester 0 is granted again for another 4 cycles.
- Fair rotation with wrap: req=4'b1111 continuously, MAX_HOLD=2 → grant order 0,1,2,3,0. Each grant lasts 2 cycles and grants are separated by 2 idle cycles.
- Priority skip: ptr=1 after grant 0 released, req=4'b1001 → grant goes to 3, not 0. After 3 releases, ptr wraps to 0 and requester 0 is granted next.
- Reset mid-ownership: assert rst during cycle 2 of a grant to requester 1 → gnt=0 on the next edge, ptr=0. After rst drops with req=4'b0010, requester 1 is granted one cycle later.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with rotating priority, a per-ownership hold limit
// and a mandatory one-cycle gap between consecutive grants.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               hold_expired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_exp;

    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_cand;
    logic               w_rel;
    logic               w_lim;
    logic [IDX_W-1:0]   w_ptr_inc;

    logic [IDX_W-1:0]   w_ptr_d;
    logic [7:0]         w_cnt_d;
    logic [NUM_REQ-1:0] w_gnt_d;
    logic               w_valid_d;
    logic [IDX_W-1:0]   w_idx_d;
    logic               w_exp_d;

    // First set request in wrap-around order starting at the pointer
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ))
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            if (!w_any && req[w_cand[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[IDX_W-1:0];
            end
        end
    end

    // Owner release / hold-limit conditions and the rotated pointer
    always_comb begin
        w_rel     = !req[r_idx];
        w_lim     = (r_cnt == 8'(MAX_HOLD - 1));
        w_ptr_inc = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_d;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_d = S_OWN;
            S_OWN:   if (w_rel || w_lim) w_state_d = S_GAP;
            S_GAP:   w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter
    always_comb begin
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_gnt_d   = r_gnt;
        w_valid_d = r_valid;
        w_idx_d   = r_idx;
        w_exp_d   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_d        = '0;
                    w_gnt_d[w_win] = 1'b1;
                    w_valid_d      = 1'b1;
                    w_idx_d        = w_win;
                    w_cnt_d        = '0;
                end
            end
            S_OWN: begin
                if (w_rel || w_lim) begin
                    w_gnt_d   = '0;
                    w_valid_d = 1'b0;
                    w_ptr_d   = w_ptr_inc;
                    w_exp_d   = !w_rel;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            default: begin
                w_gnt_d   = '0;
                w_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_exp   <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
            r_gnt   <= w_gnt_d;
            r_valid <= w_valid_d;
            r_idx   <= w_idx_d;
            r_exp   <= w_exp_d;
        end
    end

    assign gnt          = r_gnt;
    assign gnt_valid    = r_valid;
    assign gnt_idx      = r_idx;
    assign hold_expired = r_exp;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural reference model.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;
    logic         hold_expired;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_owner = -1;
    int m_last  = 0;
    int m_len   = 0;
    int m_cool  = 0;
    int m_ptr   = 0;
    bit m_exp   = 1'b0;

    rr_arbiter #(
        .NUM_REQ (N),
        .MAX_HOLD(MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .hold_expired(hold_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of ownership rules, stated in terms of grant lengths
    task automatic model_step(input logic [N-1:0] r, input logic rs);
        if (rs) begin
            m_owner = -1; m_last = 0; m_len = 0;
            m_cool  = 0;  m_ptr  = 0; m_exp = 1'b0;
        end else if (m_owner >= 0) begin
            m_exp = 1'b0;
            if (!r[m_owner] || m_len == MH) begin
                m_exp   = r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_len++;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
            m_exp  = 1'b0;
        end else begin
            m_exp = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_len   = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] eg;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("gnt",      gnt,          eg);
        chk("valid",    gnt_valid,    m_owner >= 0);
        chk("idx",      gnt_idx,      m_last);
        chk("expired",  hold_expired, m_exp);
        chk("onehot0",  $onehot0(gnt), 1);
    endtask

    int           order[$];
    logic         pv;
    int           ng, ne;
    logic [N-1:0] rq;

    initial begin
        req = '0;
        rst = 1'b1;

        // Reset with all requests high
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b1);
            chk("rst_gnt", gnt, 0);
            chk("rst_exp", hold_expired, 0);
        end

        // Full load rotation: 0,1,2,3,0
        pv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(4'b1111, 1'b0);
            if (i == 0) chk("first_gnt", gnt, 4'b0001);
            if (gnt_valid && !pv) order.push_back(int'(gnt_idx));
            pv = gnt_valid;
        end
        chk("rot_n", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("rot_ord", order[i], i % N);

        // Single short request
        cyc(4'b0000, 1'b1);
        ng = 0; ne = 0;
        for (int i = 0; i < 8; i++) begin
            cyc((i < 3) ? 4'b0100 : 4'b0000, 1'b0);
            if (gnt == 4'b0100) ng++;
            if (hold_expired) ne++;
        end
        chk("short_len", ng, 3);
        chk("short_exp", ne, 0);

        // Hold limit with a single persistent requester
        cyc(4'b0000, 1'b1);
        ng = 0; ne = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0001, 1'b0);
            if (gnt_valid) ng++;
            if (hold_expired) ne++;
        end
        chk("hold_len", ng, 8);
        chk("hold_exp", ne, 2);

        // Priority skip after requester 0 releases
        cyc(4'b0000, 1'b1);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b1001, 1'b0);
        cyc(4'b1001, 1'b0);
        chk("skip_gnt", gnt, 4'b1000);
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b0);
        chk("wrap_gnt", gnt, 4'b0001);

        // Reset in the middle of an ownership
        cyc(4'b0000, 1'b1);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b1);
        chk("midrst_gnt", gnt, 4'b0000);
        cyc(4'b0010, 1'b0);
        chk("midrst_regnt", gnt, 4'b0010);

        // Random sticky traffic with occasional resets
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            cyc(rq, $urandom_range(149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
